// File: rtl/issue_replay_buffer.sv
// -----------------------------------------------------------------------------
// issue_replay_buffer
//
// Issue-side stall responder for the 5-stage MIPS pipeline. It sits between
// fetch and decode and presents one instruction per cycle to decode and to the
// hazard detector. When the hazard detector's registered stall rejects the
// instruction issued in the previous cycle, the follower currently on the
// output is squashed, the rejected instruction is re-issued, and then the
// follower is re-issued. Fetch is held off while the replay drains.
//
// Parameters
//    NOP          encoding shown to the hazard detector on bubbles and squashes
//    CNT_W        width of the saturating replay counter
//
// Ports
//    clk          rising-edge clock
//    reset_n      asynchronous active-low reset
//    fetch_valid  fetch offers fetch_instr / fetch_pc
//    fetch_instr  offered instruction
//    fetch_pc     PC of the offered instruction
//    fetch_ready  combinational accept; transfer on fetch_valid && fetch_ready
//    stall_in     registered stall from the hazard detector; high in cycle t
//                 rejects the instruction issued in cycle t-1
//    flush        branch/jump redirect, discards everything held or issued
//    issue_valid  registered; issue_instr / issue_pc hold a real instruction
//    issue_instr  registered instruction to decode
//    issue_pc     registered PC to decode
//    issue_squash combinational; decode treats the current issue as a NOP
//    hd_instr     combinational instruction seen by the hazard detector
//    replay_count saturating count of accepted replays
// -----------------------------------------------------------------------------
module issue_replay_buffer #(
   parameter logic [31:0] NOP   = 32'h0000_0000,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fetch_valid,
   input  logic [31:0]      fetch_instr,
   input  logic [31:0]      fetch_pc,
   output logic             fetch_ready,
   input  logic             stall_in,
   input  logic             flush,
   output logic             issue_valid,
   output logic [31:0]      issue_instr,
   output logic [31:0]      issue_pc,
   output logic             issue_squash,
   output logic [31:0]      hd_instr,
   output logic [CNT_W-1:0] replay_count
);

   // HIST: what was on the output last cycle (the candidate for rejection).
   logic        hist_valid_reg, hist_valid_next;
   logic [31:0] hist_instr_reg, hist_instr_next;
   logic [31:0] hist_pc_reg,    hist_pc_next;

   // PEND: the squashed follower waiting to be re-issued after the replay.
   logic        pend_valid_reg, pend_valid_next;
   logic [31:0] pend_instr_reg, pend_instr_next;
   logic [31:0] pend_pc_reg,    pend_pc_next;

   logic             out_valid_next;
   logic [31:0]      out_instr_next;
   logic [31:0]      out_pc_next;
   logic [CNT_W-1:0] count_next;

   always_comb begin
      fetch_ready  = !flush && !stall_in && !pend_valid_reg;
      issue_squash = stall_in && issue_valid;
      // The hazard detector must never record a destination from a bubble or
      // from an instruction that is being squashed this cycle.
      hd_instr     = (issue_valid && !stall_in) ? issue_instr : NOP;

      out_valid_next  = issue_valid;
      out_instr_next  = issue_instr;
      out_pc_next     = issue_pc;
      hist_valid_next = hist_valid_reg;
      hist_instr_next = hist_instr_reg;
      hist_pc_next    = hist_pc_reg;
      pend_valid_next = pend_valid_reg;
      pend_instr_next = pend_instr_reg;
      pend_pc_next    = pend_pc_reg;
      count_next      = replay_count;

      if (flush) begin
         out_valid_next  = 1'b0;
         hist_valid_next = 1'b0;
         pend_valid_next = 1'b0;
      end else begin
         // Every non-flush edge shifts the current output into HIST.
         hist_valid_next = issue_valid;
         hist_instr_next = issue_instr;
         hist_pc_next    = issue_pc;

         if (stall_in && hist_valid_reg) begin
            // Replay: re-issue the rejected instruction, park the follower.
            out_valid_next = 1'b1;
            out_instr_next = hist_instr_reg;
            out_pc_next    = hist_pc_reg;
            if (issue_valid) begin
               pend_valid_next = 1'b1;
               pend_instr_next = issue_instr;
               pend_pc_next    = issue_pc;
            end
            if (replay_count != {CNT_W{1'b1}}) begin
               count_next = replay_count + CNT_W'(1);
            end
         end else if (stall_in) begin
            // Stall with nothing to replay: the current output is squashed
            // and dropped, a bubble follows.
            out_valid_next = 1'b0;
         end else if (pend_valid_reg) begin
            out_valid_next  = 1'b1;
            out_instr_next  = pend_instr_reg;
            out_pc_next     = pend_pc_reg;
            pend_valid_next = 1'b0;
         end else if (fetch_valid && fetch_ready) begin
            out_valid_next = 1'b1;
            out_instr_next = fetch_instr;
            out_pc_next    = fetch_pc;
         end else begin
            out_valid_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_valid    <= 1'b0;
         issue_instr    <= '0;
         issue_pc       <= '0;
         hist_valid_reg <= 1'b0;
         hist_instr_reg <= '0;
         hist_pc_reg    <= '0;
         pend_valid_reg <= 1'b0;
         pend_instr_reg <= '0;
         pend_pc_reg    <= '0;
         replay_count   <= '0;
      end else begin
         issue_valid    <= out_valid_next;
         issue_instr    <= out_instr_next;
         issue_pc       <= out_pc_next;
         hist_valid_reg <= hist_valid_next;
         hist_instr_reg <= hist_instr_next;
         hist_pc_reg    <= hist_pc_next;
         pend_valid_reg <= pend_valid_next;
         pend_instr_reg <= pend_instr_next;
         pend_pc_reg    <= pend_pc_next;
         replay_count   <= count_next;
      end
   end

endmodule

// File: doc/issue_replay_buffer.md
# issue_replay_buffer

Issue-side stall responder for the 5-stage MIPS pipeline. It sits between fetch and decode and presents one instruction per cycle to decode and to the hazard detector. When the hazard detector's registered `stall_in` rejects the previously issued instruction, this block squashes the in-flight follower and replays the rejected instruction, then the follower. It holds fetch off while the replay drains.

## Interface
- `NOP`, 32'h0000_0000: encoding driven to the hazard detector on bubbles and squashed cycles; an R-type with rd=0, so it records no destination.
- `CNT_W`, 16: width of the replay counter.

- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `fetch_valid` in 1: fetch offers `fetch_instr`/`fetch_pc`.
- `fetch_instr` in 32: offered instruction.
- `fetch_pc` in 32: PC of the offered instruction.
- `fetch_ready` out 1: combinational; transfer occurs on an edge where `fetch_valid && fetch_ready`.
- `stall_in` in 1: from the hazard detector, registered there. High in cycle t rejects the instruction issued in cycle t-1.
- `flush` in 1: branch/jump redirect; discards all held and issued instructions.
- `issue_valid` out 1: registered; `issue_instr`/`issue_pc` hold a real instruction.
- `issue_instr` out 32: registered instruction to decode.
- `issue_pc` out 32: registered PC to decode.
- `issue_squash` out 1: combinational `stall_in && issue_valid`; decode treats the current issue as a NOP.
- `hd_instr` out 32: combinational; `issue_instr` when `issue_valid && !stall_in`, else `NOP`.
- `replay_count` out CNT_W: saturating count of accepted replays.

## Operation
- State registers:
  - OUT: `issue_valid`, `issue_instr`, `issue_pc`.
  - HIST: valid, instr, pc; the instruction presented in the previous cycle.
  - PEND: valid, instr, pc; the squashed follower awaiting re-issue.
- `fetch_ready = !flush && !stall_in && !PEND.valid`.
- On every non-reset edge, priority order:
  1. `flush`: OUT, HIST and PEND valid bits all cleared. The counter is unchanged.
  2. `stall_in && HIST.valid` (replay):
     - OUT <= HIST.
     - PEND <= OUT if `issue_valid`; otherwise PEND is unchanged.
     - HIST <= OUT.
     - `replay_count` increments, saturating at all-ones.
  3. `stall_in && !HIST.valid`: protocol violation. The stall is ignored for replay purposes. OUT is still squashed this cycle and is treated as lost. OUT <= bubble; HIST <= OUT.
  4. `PEND.valid`: OUT <= PEND; PEND cleared; HIST <= OUT.
  5. Otherwise: OUT <= fetch word if transferred, else bubble (`issue_valid`=0); HIST <= OUT.
- Bubbles and squashed cycles always drive `NOP` on `hd_instr`. The hazard detector therefore never records a squashed destination, and its stall drops the cycle after a squash unless the replayed instruction hazards again.
- Repeated rejection of the same instruction replays it repeatedly. Each rejection costs 2 cycles (squash plus replay). The order A, B, C is preserved.
- PEND needs only one entry: whenever PEND is valid, OUT was loaded from HIST, not from fetch.

## Timing
- Reset (async assert, sync-safe deassert):
  - `issue_valid`=0, `issue_instr`=0, `issue_pc`=0.
  - HIST and PEND invalid; `replay_count`=0.
  - `fetch_ready`=1 and `hd_instr`=`NOP` as soon as `reset_n` is high.
- Latency: fetch transfer at edge e → `issue_*` valid in the cycle after e.
- Throughput: 1 instruction per cycle without stalls.
- `fetch_ready` is low in the stall cycle and in the replay cycle (PEND valid). It returns high in the cycle the follower re-issues.
- `flush` coincident with `stall_in`: flush wins, no replay, counter unchanged.
- `reset_n` low mid-replay: all state clears immediately; PEND content is lost.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → `issue_valid`=0, `issue_instr`=0, `replay_count`=0, `fetch_ready`=1 after release.
- Stream: A=0x2008_0001, B=0x2009_0002, C=0x200A_0003 offered back to back from edge 0 → issued in cycles 1, 2, 3; `hd_instr` equals the issued instruction each cycle; no `fetch_ready` drop.
- Single stall: issue A in cycle 1, pulse `stall_in` in cycle 2 →
  - cycle 2: B with `issue_squash`=1, `hd_instr`=0, `fetch_ready`=0.
  - cycle 3: A; `fetch_ready`=0.
  - cycle 4: B.
  - cycle 5: C.
  - `replay_count`=1.
- Double stall: as above, plus `stall_in` again in cycle 4 → sequence B(sq), A, B(sq), A, B, C; `replay_count`=2.
- Flush in cycle 3 of the single-stall case → cycle 4 `issue_valid`=0, PEND cleared; next fetch word issues in cycle 5; B never appears.
- Async reset mid-replay: drop `reset_n` during cycle 3 → outputs clear without a clock edge; after release, the stream restarts cleanly with `replay_count`=0.
